// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative 32-cycle MUL/DIVU/REMU unit, and the EX/MEM register.
// Optional operand bypass from EX/MEM and write-back is enabled by defining EX_FWD_EN.
module ex_stage #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_1_in,
  input  logic [WIDTH-1:0] data_2_in,
  input  logic [4:0]       rs_in,
  input  logic [4:0]       rt_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       shamt_in,
  input  logic [WIDTH-1:0] sign_imm_in,
  input  logic             reg_wen_in,
  input  logic             reg_des_in,
  input  logic             dmem_alu_in,
  input  logic             mem_wen_in,
  input  logic             jr_in,
  input  logic             alu_sel_in,
  input  logic [4:0]       alu_code_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             wb_wen_in,
  input  logic [4:0]       wb_addr_in,
  input  logic [WIDTH-1:0] wb_data_in,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic [4:0]       dest_out,
  output logic             reg_wen_out,
  output logic             dmem_alu_out,
  output logic             mem_wen_out,
  output logic             jr_out,
  output logic [WIDTH-1:0] jr_target_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             stall_out
);

  localparam logic [4:0] LP_LAST = 5'(MD_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] w_d1, w_d2, w_a, w_b, w_alu;
  logic [4:0]       w_dest;
  logic             w_is_md;

`ifdef EX_FWD_EN
  logic w_exm_ok, w_wb_ok;
  assign w_exm_ok = reg_wen_out && !dmem_alu_out && (dest_out != 5'd0);
  assign w_wb_ok  = wb_wen_in && (wb_addr_in != 5'd0);

  always_comb begin
    w_d1 = data_1_in;
    w_d2 = data_2_in;
    if (w_exm_ok && (dest_out == rs_in))        w_d1 = alu_result_out;
    else if (w_wb_ok && (wb_addr_in == rs_in))  w_d1 = wb_data_in;
    if (w_exm_ok && (dest_out == rt_in))        w_d2 = alu_result_out;
    else if (w_wb_ok && (wb_addr_in == rt_in))  w_d2 = wb_data_in;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{wb_wen_in, wb_addr_in, wb_data_in, rs_in};
  assign w_d1 = data_1_in;
  assign w_d2 = data_2_in;
`endif

  assign w_a     = w_d1;
  assign w_b     = alu_sel_in ? sign_imm_in : w_d2;
  assign w_dest  = reg_des_in ? rd_in : rt_in;
  assign w_is_md = (alu_code_in == 5'd16) || (alu_code_in == 5'd17) || (alu_code_in == 5'd18);

  always_comb begin
    w_alu = '0;
    case (alu_code_in)
      5'd0:  w_alu = w_a + w_b;
      5'd1:  w_alu = w_a - w_b;
      5'd2:  w_alu = w_a & w_b;
      5'd3:  w_alu = w_a | w_b;
      5'd4:  w_alu = w_a ^ w_b;
      5'd5:  w_alu = ~(w_a | w_b);
      5'd6:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      5'd7:  w_alu = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      5'd8:  w_alu = w_d2 << shamt_in;
      5'd9:  w_alu = w_d2 >> shamt_in;
      5'd10: w_alu = $signed(w_d2) >>> shamt_in;
      5'd11: w_alu = w_b << 16;
      5'd12: w_alu = pc_in + WIDTH'(4);
      default: w_alu = '0;
    endcase
  end

  // MUL: x = multiplicand (shifts left), y = multiplier (shifts right), acc = product.
  // DIV: x = dividend shifting out / quotient shifting in, y = divisor, acc = remainder.
  logic [WIDTH-1:0] r_md_x, r_md_y, r_md_acc, r_md_a, r_md_st, r_md_pc;
  logic [4:0]       r_md_code, r_md_dest;
  logic             r_md_rw, r_md_da, r_md_mw, r_md_jr;
  logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_acc_nxt, w_md_res;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_fits;

  assign w_rem_sh = {r_md_acc, r_md_x[WIDTH-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_md_y});

  always_comb begin
    w_x_nxt   = r_md_x;
    w_y_nxt   = r_md_y;
    w_acc_nxt = r_md_acc;
    if (r_md_code == 5'd16) begin
      w_acc_nxt = r_md_acc + (r_md_y[0] ? r_md_x : '0);
      w_x_nxt   = r_md_x << 1;
      w_y_nxt   = r_md_y >> 1;
    end else begin
      w_x_nxt   = {r_md_x[WIDTH-2:0], w_fits};
      w_acc_nxt = w_fits ? (w_rem_sh[WIDTH-1:0] - r_md_y) : w_rem_sh[WIDTH-1:0];
    end
    w_md_res = (r_md_code == 5'd17) ? w_x_nxt : w_acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_is_md) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == LP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    case (r_state)
      S_IDLE:  stall_out = w_is_md;
      S_BUSY:  stall_out = (r_cnt != LP_LAST);
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_md_x    <= '0;
      r_md_y    <= '0;
      r_md_acc  <= '0;
      r_md_a    <= '0;
      r_md_st   <= '0;
      r_md_pc   <= '0;
      r_md_code <= '0;
      r_md_dest <= '0;
      r_md_rw   <= 1'b0;
      r_md_da   <= 1'b0;
      r_md_mw   <= 1'b0;
      r_md_jr   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_is_md) begin
        r_cnt     <= '0;
        r_md_x    <= w_a;
        r_md_y    <= w_b;
        r_md_acc  <= '0;
        r_md_a    <= w_a;
        r_md_st   <= w_d2;
        r_md_pc   <= pc_in;
        r_md_code <= alu_code_in;
        r_md_dest <= w_dest;
        r_md_rw   <= reg_wen_in;
        r_md_da   <= dmem_alu_in;
        r_md_mw   <= mem_wen_in;
        r_md_jr   <= jr_in;
      end
    end else begin
      r_cnt    <= r_cnt + 5'd1;
      r_md_x   <= w_x_nxt;
      r_md_y   <= w_y_nxt;
      r_md_acc <= w_acc_nxt;
    end
  end

  // EX/MEM register: bubble unless a single-cycle op retires or the MD unit finishes.
  always_ff @(posedge clk) begin
    alu_result_out <= '0;
    store_data_out <= '0;
    dest_out       <= '0;
    reg_wen_out    <= 1'b0;
    dmem_alu_out   <= 1'b0;
    mem_wen_out    <= 1'b0;
    jr_out         <= 1'b0;
    jr_target_out  <= '0;
    pc_out         <= '0;
    if (!rst) begin
      if ((r_state == S_IDLE) && !w_is_md) begin
        alu_result_out <= w_alu;
        store_data_out <= w_d2;
        dest_out       <= w_dest;
        reg_wen_out    <= reg_wen_in;
        dmem_alu_out   <= dmem_alu_in;
        mem_wen_out    <= mem_wen_in;
        jr_out         <= jr_in;
        jr_target_out  <= w_a;
        pc_out         <= pc_in;
      end else if ((r_state == S_BUSY) && (r_cnt == LP_LAST)) begin
        alu_result_out <= w_md_res;
        store_data_out <= r_md_st;
        dest_out       <= r_md_dest;
        reg_wen_out    <= r_md_rw;
        dmem_alu_out   <= r_md_da;
        mem_wen_out    <= r_md_mw;
        jr_out         <= r_md_jr;
        jr_target_out  <= r_md_a;
        pc_out         <= r_md_pc;
      end
    end
  end

endmodule
